// File: rtl/m_result_stage.sv
// rtl/m_result_stage.sv - M-extension result stage: sign fix-up, div special cases, writeback handshake
// Build option: M_SPECIAL_FAST_EN lets divide-by-zero/overflow results bypass the FIX cycle.
module m_result_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            done_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic            rs1_sign_i,
    input  logic            rs2_sign_i,
    input  logic            div_zero_i,
    input  logic            div_ovf_i,
    input  logic [RD_W-1:0] rd_i,
    input  logic [XLEN-1:0] r_i,
    input  logic [XLEN-1:0] z_i,
    output logic            busy_o,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [RD_W-1:0] result_rd_o
);

    typedef enum logic [1:0] {IDLE, FIX, OUT} state_t;

`ifdef M_SPECIAL_FAST_EN
    localparam state_t SPECIAL_NEXT = OUT;
`else
    localparam state_t SPECIAL_NEXT = FIX;
`endif

    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              neg_q, neg_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
        end
    end

    // funct3[2] = divide family, funct3[1] = remainder, funct3[0] = unsigned.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: begin
                if (done_i) begin
                    rd_d    = rd_i;
                    neg_d   = 1'b0;
                    state_d = OUT;
                    if (!funct3_i[2]) begin
                        result_d = (funct3_i[1:0] == 2'b00) ? r_i : z_i;
                    end else if (div_zero_i) begin
                        result_d = funct3_i[1] ? rs1_i : '1;
                        state_d  = SPECIAL_NEXT;
                    end else if (div_ovf_i && !funct3_i[0]) begin
                        result_d = funct3_i[1] ? '0 : INT_MIN;
                        state_d  = SPECIAL_NEXT;
                    end else if (funct3_i[0]) begin
                        result_d = funct3_i[1] ? r_i : z_i;
                    end else begin
                        // Remainder takes the dividend's sign; quotient the xor of both.
                        result_d = funct3_i[1] ? r_i : z_i;
                        neg_d    = funct3_i[1] ? rs1_sign_i : (rs1_sign_i ^ rs2_sign_i);
                        state_d  = FIX;
                    end
                end
            end
            FIX: begin
                if (neg_q) begin
                    result_d = ~result_q + ONE;
                end
                state_d = OUT;
            end
            OUT: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o         = (state_q != IDLE);
    assign result_valid_o = (state_q == OUT);
    assign result_o       = result_q;
    assign result_rd_o    = rd_q;

    a_no_done_while_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        !(done_i && busy_o))
        else $warning("done raised while busy; ignored");

endmodule

// File: tb/tb_m_result_stage.sv
// tb/tb_m_result_stage.sv - scoreboard bench for m_result_stage against RISC-V M semantics
module tb_m_result_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic        rs1_sign = 1'b0;
    logic        rs2_sign = 1'b0;
    logic        div_zero = 1'b0;
    logic        div_ovf = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] r_in = '0;
    logic [31:0] z_in = '0;
    logic        busy;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  result_rd;

    m_result_stage dut (
        .clk_i(clk), .rst_i(rst), .done_i(done), .funct3_i(funct3), .rs1_i(rs1),
        .rs1_sign_i(rs1_sign), .rs2_sign_i(rs2_sign), .div_zero_i(div_zero),
        .div_ovf_i(div_ovf), .rd_i(rd), .r_i(r_in), .z_i(z_in), .busy_o(busy),
        .result_valid_o(result_valid), .result_ready_i(result_ready),
        .result_o(result), .result_rd_o(result_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          issue;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   seen = 0;
    bit   hold = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every cycle the output is valid, so it also proves stability under backpressure.
    always @(negedge clk) begin
        if (!rst) begin
            if (result_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    if (!seen) begin
                        chk("latency", 32'(cyc - q[0].issue), 32'(q[0].lat));
                        seen = 1;
                    end
                    chk("result", result, q[0].res);
                    chk("result_rd", {27'd0, result_rd}, {27'd0, q[0].rd});
                    chk("busy_in_out", {31'd0, busy}, 32'd1);
                end
            end
            result_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (result_valid && result_ready && q.size() != 0) begin
                void'(q.pop_front());
                seen = 0;
            end
        end
    end

    // Reference: RISC-V M results from the architectural operands, plus the datapath's R/Z hand-off.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dst);
        logic [63:0] ea, eb, p;
        logic [31:0] ma, mb, res;
        bit          sgn, ovf, special;
        exp_t        e;
        int          n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("busy_timeout", 32'd1, 32'd0);
        sgn = f[2] && !f[0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ma  = (sgn && a[31]) ? -a : a;
        mb  = (sgn && b[31]) ? -b : b;
        ea  = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb  = (f == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p   = ea * eb;
        case (f)
            3'd0:    res = p[31:0];
            3'd4:    res = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'd5:    res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    res = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            3'd7:    res = (b == 0) ? a : a % b;
            default: res = p[63:32];
        endcase
        special = f[2] && ((b == 0) || (ovf && !f[0]));
`ifdef M_SPECIAL_FAST_EN
        e.lat = (!f[2] || special || f[0]) ? 1 : 2;
`else
        e.lat = (!f[2] || (f[0] && !special)) ? 1 : 2;
`endif
        e.res = res;
        e.rd = dst;
        e.issue = cyc;
        q.push_back(e);
        funct3 = f;
        rs1 = a;
        rs1_sign = a[31];
        rs2_sign = b[31];
        div_zero = (b == 0);
        div_ovf = ovf;
        rd = dst;
        r_in = f[2] ? ((mb != 0) ? ma % mb : $urandom) : p[31:0];
        z_in = f[2] ? ((mb != 0) ? ma / mb : $urandom) : p[63:32];
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", {27'd0, result_rd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(3'd3, 32'h2468_ACF0, 32'h8000_0000, 5'd1);
        issue(3'd4, -32'd7, 32'd2, 5'd2);
        issue(3'd6, -32'd7, 32'd2, 5'd3);
        issue(3'd4, 32'd5, 32'd0, 5'd4);
        issue(3'd6, 32'd42, 32'd0, 5'd5);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        drain();

        hold = 1;
        issue(3'd0, 32'd3, 32'd5, 5'd9);
        begin
            int n = 0;
            while (!result_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) chk("hold_valid_timeout", 32'd1, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                funct3 = 3'd5;
                rd = 5'd30;
                r_in = 32'hDEAD_BEEF;
                z_in = 32'hDEAD_BEEF;
                done = 1'b1;
            end else begin
                done = 1'b0;
            end
            @(negedge clk);
        end
        done = 1'b0;
        chk("hold_busy", {31'd0, busy}, 32'd1);
        hold = 0;
        drain();

        issue(3'd4, -32'd7, 32'd2, 5'd10);
        rst = 1'b1;
        #1;
        chk("midfix_rst_valid", {31'd0, result_valid}, 32'd0);
        chk("midfix_rst_result", result, 32'd0);
        chk("midfix_rst_busy", {31'd0, busy}, 32'd0);
        q.delete();
        seen = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        issue(3'd0, 32'd7, 32'd1, 5'd11);
        drain();

        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
